v_query_walker: RTL and testbench
=================================

# v_query_walker

Query initiator that drives the list query bus of the query pipeline. Given a product ID, it walks every level `0..ENTRIES_N-1` with one query per level, retries levels reported busy, and streams the valid `(level, key, size)` entries out through a small output FIFO with valid/ready handshake. It sits between the host-side snapshot/export logic and the query pipeline, acting as the requesting end of the `i_lut_*` / `o_lut_*` interface.

## Interface
- `ENTRIES_N`, `cfg_pkg::ENTRIES_N`: levels per product; walk length.
- `RETRY_MAX`, 3: consecutive errors on one level before that level is skipped; must be ≥1.
- `OUT_DEPTH`, 4: output FIFO entries; must be ≥2.

Ports:
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `i_req_vld` in 1: walk request.
- `i_req_prod_id` in `v_pkg::id_t`: product to walk.
- `o_req_rdy` out 1: request accepted when `i_req_vld & o_req_rdy`.
- `o_lut_vld` out 1: query issue.
- `o_lut_prod_id` out `v_pkg::id_t`: query product.
- `o_lut_level` out `v_pkg::level_t`: query level.
- `i_lut_vld_r` in 1: query response valid, exactly 1 cycle after `o_lut_vld`.
- `i_lut_key` in `v_pkg::key_t`: response key.
- `i_lut_size` in `v_pkg::volume_t`: response volume.
- `i_lut_error` in 1: busy or invalid entry.
- `i_lut_listsize` in `v_pkg::listsize_t`: list occupancy.
- `o_rsp_vld` out 1: output entry valid.
- `o_rsp_level` out `v_pkg::level_t`: entry level.
- `o_rsp_key` out `v_pkg::key_t`: entry key.
- `o_rsp_size` out `v_pkg::volume_t`: entry volume.
- `i_rsp_rdy` in 1: output consumer ready.
- `o_done_vld` out 1: single-cycle walk-complete pulse.
- `o_done_cnt` out `$clog2(ENTRIES_N+1)`: entries emitted this walk.

## Operation
- FSM states are IDLE, ISSUE, WAIT, DRAIN, DONE.
- IDLE:
  - `o_req_rdy`=1.
  - On accept, latch the product ID; clear `level`, `retry`, `found` and `listsize_vld`; go to ISSUE.
- ISSUE:
  - Assert `o_lut_vld` with the latched ID and current `level` only when the FIFO has a free slot (occupancy < `OUT_DEPTH`); otherwise stall in ISSUE with `o_lut_vld`=0.
  - On issue, go to WAIT.
- WAIT, on `i_lut_vld_r`:
  - No error:
    - Push `{level, key, size}` to the FIFO and increment `found`.
    - On the first such response, latch `i_lut_listsize` and set `listsize_vld`.
    - Clear `retry` and advance `level`.
  - Error with `retry < RETRY_MAX-1`: increment `retry` and reissue the same level.
  - Error with `retry == RETRY_MAX-1`: skip the level, clear `retry` and advance `level`.
  - After the level advances: if the old level was `ENTRIES_N-1`, go to DRAIN; else go to ISSUE.
  - `i_lut_vld_r`=0 in WAIT is a protocol violation (SVA assertion). The FSM remains in WAIT.
- DRAIN: wait for the FIFO to empty, then go to DONE.
- DONE: `o_done_vld`=1 with `o_done_cnt=found`; go to IDLE next cycle.
- Output FIFO:
  - Registered; pop on `o_rsp_vld & i_rsp_rdy`.
  - A push and a pop in the same cycle are legal when full or empty.
  - Order is preserved, so entries leave in ascending level order.
- `found` saturates at `ENTRIES_N`. No wrap occurs: `level` is compared to `ENTRIES_N-1` before incrementing.

## Timing
- Reset values:
  - FSM=IDLE, FIFO empty.
  - `o_req_rdy`=1.
  - `o_lut_vld`=0, `o_rsp_vld`=0, `o_done_vld`=0.
  - `o_lut_prod_id`, `o_lut_level`, `o_done_cnt`, `o_rsp_*` data = 0.
- Request accepted at cycle T: first `o_lut_vld` at T+1, response at T+2, next issue no earlier than T+3. The minimum is 2 cycles per query.
- An entry pushed at cycle N shows `o_rsp_vld` at N+1.
- `o_done_vld` asserts the cycle after the FIFO becomes empty in DRAIN. It never precedes the last `o_rsp_vld` handshake.
- Reset mid-walk: the walk is aborted with no done pulse; the FIFO is flushed; any outstanding response arriving after reset is ignored.
- `i_req_vld` while not IDLE is ignored (`o_req_rdy`=0).

## Configuration
- `V_QUERY_WALKER_EARLY_TERM_EN`:
  - Defined: in WAIT, after a successful push, if `listsize_vld` and `found == latched listsize`, go directly to DRAIN and skip the remaining levels. This saves `RETRY_MAX` queries per trailing invalid level.
  - Undefined: all `ENTRIES_N` levels are always walked, and `i_lut_listsize` is unused.

## Test plan
- Empty list (ENTRIES_N=4, RETRY_MAX=3): every response has error=1 -> 12 queries issued, no `o_rsp_vld`, `o_done_vld` with cnt=0 at T+25.
- Levels 0 and 2 valid, listsize=2, `i_rsp_rdy`=1:
  - Responses in order -> entries L0 then L2.
  - With the macro: 5 queries, cnt=2, level 3 not queried.
  - Without the macro: 8 queries, cnt=2.
- Busy retry: level 1 errors twice then succeeds -> exactly 3 queries at level 1, entry L1 emitted once, no skip.
- Backpressure (OUT_DEPTH=2, `i_rsp_rdy`=0, all 4 levels valid):
  - After 2 pushes, `o_lut_vld` stays 0 in ISSUE.
  - Raising `i_rsp_rdy` resumes issue.
  - All 4 entries arrive in order; done follows the last pop.
- Reset asserted in WAIT with 1 entry in FIFO -> `o_rsp_vld`=0 and `o_req_rdy`=1 immediately, no done pulse; the next request walks cleanly.
- Request held high during a walk -> ignored until DONE; accepted in the following IDLE cycle.

Source files
------------

// File: rtl/v_query_walker.sv
// v_query_walker: walks levels 0..ENTRIES_N-1 of one product on the list query
// bus, retries busy levels, and streams valid (level, key, size) entries out
// through a small registered FIFO with a valid/ready handshake.
// Optional feature macro: V_QUERY_WALKER_EARLY_TERM_EN (stop the walk once the
// number of entries found matches the reported list occupancy).

package cfg_pkg;
    localparam int ENTRIES_N = 4;
endpackage

package v_pkg;
    typedef logic [7:0]  id_t;
    typedef logic [3:0]  level_t;
    typedef logic [15:0] key_t;
    typedef logic [15:0] volume_t;
    typedef logic [7:0]  listsize_t;
endpackage

module v_query_walker #(
    parameter int ENTRIES_N = cfg_pkg::ENTRIES_N,
    parameter int RETRY_MAX = 3,
    parameter int OUT_DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_req_vld,
    input  v_pkg::id_t                       i_req_prod_id,
    output logic                             o_req_rdy,
    output logic                             o_lut_vld,
    output v_pkg::id_t                       o_lut_prod_id,
    output v_pkg::level_t                    o_lut_level,
    input  logic                             i_lut_vld_r,
    input  v_pkg::key_t                      i_lut_key,
    input  v_pkg::volume_t                   i_lut_size,
    input  logic                             i_lut_error,
    input  v_pkg::listsize_t                 i_lut_listsize,
    output logic                             o_rsp_vld,
    output v_pkg::level_t                    o_rsp_level,
    output v_pkg::key_t                      o_rsp_key,
    output v_pkg::volume_t                   o_rsp_size,
    input  logic                             i_rsp_rdy,
    output logic                             o_done_vld,
    output logic [$clog2(ENTRIES_N+1)-1:0]   o_done_cnt
);
    localparam int FW = $clog2(ENTRIES_N + 1);
    localparam int RW = $clog2(RETRY_MAX + 1);
    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = $clog2(OUT_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, DONE} state_t;

    state_t          state;
    v_pkg::level_t   level;
    logic [RW-1:0]   retry;
    logic [FW-1:0]   found;
    logic [FW-1:0]   found_nxt;

    v_pkg::level_t   mem_level [OUT_DEPTH];
    v_pkg::key_t     mem_key   [OUT_DEPTH];
    v_pkg::volume_t  mem_size  [OUT_DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic [CW-1:0]   count_nxt;

    logic            push;
    logic            pop;
    logic            last_try;
    logic            advance;
    logic            early;
    logic            finish;

`ifdef V_QUERY_WALKER_EARLY_TERM_EN
    v_pkg::listsize_t listsize;
    logic             listsize_vld;
`else
    logic             unused_listsize;
    assign unused_listsize = ^i_lut_listsize;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(OUT_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Handshake decode, FIFO occupancy forecast and walk-advance decisions.
    always_comb begin
        push      = (state == WAIT) && i_lut_vld_r && !i_lut_error;
        pop       = (count != '0) && i_rsp_rdy;
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + 1'b1;
        end else if (!push && pop) begin
            count_nxt = count - 1'b1;
        end
        found_nxt = (found == FW'(ENTRIES_N)) ? found : found + 1'b1;
        last_try  = (retry == RW'(RETRY_MAX - 1));
        advance   = (state == WAIT) && i_lut_vld_r && (!i_lut_error || last_try);
        early     = 1'b0;
`ifdef V_QUERY_WALKER_EARLY_TERM_EN
        // The first success supplies the occupancy in the same cycle it is latched.
        if (push) begin
            early = (int'(found_nxt) == int'(listsize_vld ? listsize : i_lut_listsize));
        end
`endif
        finish    = advance && ((level == v_pkg::level_t'(ENTRIES_N - 1)) || early);
    end

    // Issue only when the response is guaranteed a FIFO slot.
    assign o_lut_vld   = (state == ISSUE) && (count < CW'(OUT_DEPTH));
    assign o_lut_level = level;
    assign o_rsp_vld   = (count != '0);
    assign o_rsp_level = mem_level[rd_ptr];
    assign o_rsp_key   = mem_key[rd_ptr];
    assign o_rsp_size  = mem_size[rd_ptr];

    // Walk sequencer with registered request-ready and done outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            o_req_rdy     <= 1'b1;
            o_lut_prod_id <= '0;
            level         <= '0;
            retry         <= '0;
            found         <= '0;
            o_done_vld    <= 1'b0;
            o_done_cnt    <= '0;
`ifdef V_QUERY_WALKER_EARLY_TERM_EN
            listsize      <= '0;
            listsize_vld  <= 1'b0;
`endif
        end else begin
            o_done_vld <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_req_vld) begin
                        o_lut_prod_id <= i_req_prod_id;
                        level         <= '0;
                        retry         <= '0;
                        found         <= '0;
                        o_req_rdy     <= 1'b0;
                        state         <= ISSUE;
`ifdef V_QUERY_WALKER_EARLY_TERM_EN
                        listsize_vld  <= 1'b0;
`endif
                    end
                end
                ISSUE: begin
                    if (o_lut_vld) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (i_lut_vld_r) begin
                        if (!i_lut_error) begin
                            found <= found_nxt;
                            retry <= '0;
`ifdef V_QUERY_WALKER_EARLY_TERM_EN
                            if (!listsize_vld) begin
                                listsize     <= i_lut_listsize;
                                listsize_vld <= 1'b1;
                            end
`endif
                        end else if (!last_try) begin
                            retry <= retry + 1'b1;
                        end else begin
                            retry <= '0;
                        end
                        if (finish) begin
                            // A push here keeps the FIFO non-empty, so found is final.
                            if (count_nxt == '0) begin
                                o_done_vld <= 1'b1;
                                o_done_cnt <= found;
                                state      <= DONE;
                            end else begin
                                state <= DRAIN;
                            end
                        end else begin
                            if (advance) begin
                                level <= level + 1'b1;
                            end
                            state <= ISSUE;
                        end
                    end
                end
                DRAIN: begin
                    if (count_nxt == '0) begin
                        o_done_vld <= 1'b1;
                        o_done_cnt <= found;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    o_req_rdy <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output FIFO storage and pointers; reset flushes any pending entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < OUT_DEPTH; i++) begin
                mem_level[i] <= '0;
                mem_key[i]   <= '0;
                mem_size[i]  <= '0;
            end
        end else begin
            count <= count_nxt;
            if (push) begin
                mem_level[wr_ptr] <= level;
                mem_key[wr_ptr]   <= i_lut_key;
                mem_size[wr_ptr]  <= i_lut_size;
                wr_ptr            <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
        end
    end

    a_rsp_in_wait: assert property (@(posedge clk) disable iff (rst) (state == WAIT) |-> i_lut_vld_r);

endmodule

// File: tb/tb_v_query_walker.sv
// Bench for v_query_walker: a behavioural query responder answers one cycle
// after each issue, good entries are queued as expectations and popped as the
// DUT hands them out.
module tb_v_query_walker;
    localparam int EN = 4;
    localparam int RM = 3;
    localparam int OD = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_req_vld;
    logic [7:0]  i_req_prod_id;
    logic        o_req_rdy;
    logic        o_lut_vld;
    logic [7:0]  o_lut_prod_id;
    logic [3:0]  o_lut_level;
    logic        i_lut_vld_r;
    logic [15:0] i_lut_key;
    logic [15:0] i_lut_size;
    logic        i_lut_error;
    logic [7:0]  i_lut_listsize;
    logic        o_rsp_vld;
    logic [3:0]  o_rsp_level;
    logic [15:0] o_rsp_key;
    logic [15:0] o_rsp_size;
    logic        i_rsp_rdy;
    logic        o_done_vld;
    logic [2:0]  o_done_cnt;

    v_query_walker #(.ENTRIES_N(EN), .RETRY_MAX(RM), .OUT_DEPTH(OD)) dut (
        .clk(clk), .rst(rst),
        .i_req_vld(i_req_vld), .i_req_prod_id(i_req_prod_id), .o_req_rdy(o_req_rdy),
        .o_lut_vld(o_lut_vld), .o_lut_prod_id(o_lut_prod_id), .o_lut_level(o_lut_level),
        .i_lut_vld_r(i_lut_vld_r), .i_lut_key(i_lut_key), .i_lut_size(i_lut_size),
        .i_lut_error(i_lut_error), .i_lut_listsize(i_lut_listsize),
        .o_rsp_vld(o_rsp_vld), .o_rsp_level(o_rsp_level), .o_rsp_key(o_rsp_key),
        .o_rsp_size(o_rsp_size), .i_rsp_rdy(i_rsp_rdy),
        .o_done_vld(o_done_vld), .o_done_cnt(o_done_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    // responder configuration and bookkeeping
    bit          lvl_valid [EN];
    int          err_left  [EN];
    int          qcnt      [EN];
    int          total_q;
    int          first_q;
    logic [7:0]  cur_id;
    logic [7:0]  cur_ls;
    logic [35:0] sb [$];
    int          n_rsp = 0;
    int          n_done = 0;
    int          done_cyc = 0;
    int          done_cnt_seen = 0;
    int          n_acc = 0;
    int          acc_cyc = 0;
    int          acc_at_done = 0;

    logic        r_p;
    logic [3:0]  r_lvl;
    logic [7:0]  r_id;
    logic [35:0] e_ent;

    // Query responder: answers exactly one cycle after each issue.
    initial begin
        i_lut_vld_r    = 1'b0;
        i_lut_key      = '0;
        i_lut_size     = '0;
        i_lut_error    = 1'b0;
        i_lut_listsize = '0;
        forever begin
            @(negedge clk);
            r_p   = o_lut_vld && !rst;
            r_lvl = o_lut_level;
            r_id  = o_lut_prod_id;
            if (r_p) begin
                total_q++;
                qcnt[int'(r_lvl)]++;
                if (first_q < 0) first_q = cyc;
                chk("lut_prod_id", r_id, cur_id);
            end
            @(posedge clk);
            #1;
            i_lut_vld_r    = r_p;
            i_lut_error    = 1'b0;
            i_lut_key      = {4'hC, cur_id[3:0], 4'h0, r_lvl};
            i_lut_size     = 16'h0010 + 16'(r_lvl) * 16'd3;
            i_lut_listsize = cur_ls;
            if (r_p) begin
                if (!lvl_valid[int'(r_lvl)] || err_left[int'(r_lvl)] > 0) begin
                    i_lut_error = 1'b1;
                    if (err_left[int'(r_lvl)] > 0) err_left[int'(r_lvl)]--;
                end else begin
                    sb.push_back({r_lvl, i_lut_key, i_lut_size});
                end
            end
        end
    end

    // Output monitor: scoreboard pops, done pulses, request accepts.
    always @(negedge clk) begin
        if (!rst) begin
            if (i_req_vld && o_req_rdy) begin
                n_acc++;
                acc_cyc = cyc;
            end
            if (o_rsp_vld && i_rsp_rdy) begin
                n_rsp++;
                if (sb.size() == 0) begin
                    chk("rsp_unexpected", 1, 0);
                end else begin
                    e_ent = sb.pop_front();
                    chk("rsp_entry", {o_rsp_level, o_rsp_key, o_rsp_size}, e_ent);
                end
            end
            if (o_done_vld) begin
                n_done++;
                done_cyc      = cyc;
                done_cnt_seen = int'(o_done_cnt);
                acc_at_done   = n_acc;
                chk("done_fifo_empty", o_rsp_vld, 0);
                chk("done_sb_empty", sb.size(), 0);
            end
        end
    end

    task automatic setup(input logic [3:0] vmask, input int l1_err, input logic [7:0] ls, input logic [7:0] id);
        for (int i = 0; i < EN; i++) begin
            lvl_valid[i] = vmask[i];
            err_left[i]  = 0;
            qcnt[i]      = 0;
        end
        err_left[1] = l1_err;
        total_q = 0;
        first_q = -1;
        n_rsp   = 0;
        cur_ls  = ls;
        cur_id  = id;
    endtask

    task automatic start_walk(output int t);
        @(posedge clk);
        #1;
        i_req_vld     = 1'b1;
        i_req_prod_id = cur_id;
        t = -1;
        for (int k = 0; k < 200 && t < 0; k++) begin
            @(negedge clk);
            if (o_req_rdy) t = cyc;
        end
        if (t < 0) chk("req_accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        i_req_vld = 1'b0;
    endtask

    task automatic wait_done(input int d0, input int budget);
        int k = 0;
        while (n_done == d0 && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (n_done == d0) chk("done_timeout", 0, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int t0;
    int d0;
    int a0;
    int k;

    initial begin
        rst           = 1'b1;
        i_req_vld     = 1'b0;
        i_req_prod_id = '0;
        i_rsp_rdy     = 1'b1;
        setup(4'b0000, 0, 8'd0, 8'h00);
        #12;
        chk("rst_req_rdy", o_req_rdy, 1);
        chk("rst_lut_vld", o_lut_vld, 0);
        chk("rst_rsp_vld", o_rsp_vld, 0);
        chk("rst_done_vld", o_done_vld, 0);
        chk("rst_lut_level", o_lut_level, 0);
        chk("rst_lut_prod", o_lut_prod_id, 0);
        chk("rst_done_cnt", o_done_cnt, 0);
        chk("rst_rsp_data", {o_rsp_level, o_rsp_key, o_rsp_size}, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // empty list: every query errors
        setup(4'b0000, 0, 8'd0, 8'h11);
        d0 = n_done;
        start_walk(t0);
        wait_done(d0, 100);
        chk("empty_first_issue", first_q - t0, 1);
        chk("empty_queries", total_q, 12);
        chk("empty_rsp", n_rsp, 0);
        chk("empty_cnt", done_cnt_seen, 0);
        chk("empty_done_cycle", done_cyc - t0, 25);

        // levels 0 and 2 valid, listsize 2
        setup(4'b0101, 0, 8'd2, 8'h22);
        d0 = n_done;
        start_walk(t0);
        wait_done(d0, 100);
        chk("sparse_rsp", n_rsp, 2);
        chk("sparse_cnt", done_cnt_seen, 2);
`ifdef V_QUERY_WALKER_EARLY_TERM_EN
        chk("sparse_queries", total_q, 5);
        chk("sparse_l3_queries", qcnt[3], 0);
`else
        chk("sparse_queries", total_q, 8);
        chk("sparse_l3_queries", qcnt[3], 3);
`endif

        // busy retry on level 1
        setup(4'b1111, 2, 8'd4, 8'h33);
        d0 = n_done;
        start_walk(t0);
        wait_done(d0, 100);
        chk("retry_l1_queries", qcnt[1], 3);
        chk("retry_queries", total_q, 6);
        chk("retry_rsp", n_rsp, 4);
        chk("retry_cnt", done_cnt_seen, 4);

        // backpressure with a 2-entry FIFO
        setup(4'b1111, 0, 8'd4, 8'h44);
        i_rsp_rdy = 1'b0;
        d0 = n_done;
        start_walk(t0);
        k = 0;
        while (total_q < 2 && k < 50) begin
            @(negedge clk);
            k++;
        end
        repeat (10) @(negedge clk);
        chk("bp_stall_queries", total_q, 2);
        chk("bp_stall_lut_vld", o_lut_vld, 0);
        chk("bp_rsp_vld", o_rsp_vld, 1);
        @(posedge clk);
        #1 i_rsp_rdy = 1'b1;
        wait_done(d0, 100);
        chk("bp_queries", total_q, 4);
        chk("bp_rsp", n_rsp, 4);
        chk("bp_cnt", done_cnt_seen, 4);

        // reset in WAIT with one entry held in the FIFO
        setup(4'b1111, 0, 8'd4, 8'h55);
        i_rsp_rdy = 1'b0;
        start_walk(t0);
        k = 0;
        while (!(o_lut_vld && o_lut_level == 4'd1) && k < 50) begin
            @(negedge clk);
            k++;
        end
        chk("rstw_reach_l1", o_lut_level, 1);
        d0 = n_done;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("rstw_rsp_vld", o_rsp_vld, 0);
        chk("rstw_req_rdy", o_req_rdy, 1);
        chk("rstw_lut_vld", o_lut_vld, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        i_rsp_rdy = 1'b1;
        repeat (6) @(negedge clk);
        chk("rstw_no_done", n_done, d0);
        chk("rstw_idle_rdy", o_req_rdy, 1);
        setup(4'b1111, 0, 8'd4, 8'h56);
        start_walk(t0);
        wait_done(d0, 100);
        chk("rstw_clean_queries", total_q, 4);
        chk("rstw_clean_rsp", n_rsp, 4);
        chk("rstw_clean_cnt", done_cnt_seen, 4);

        // request held high through a whole walk
        setup(4'b1111, 0, 8'd4, 8'h66);
        a0 = n_acc;
        d0 = n_done;
        @(posedge clk);
        #1;
        i_req_vld     = 1'b1;
        i_req_prod_id = cur_id;
        wait_done(d0, 100);
        chk("held_single_accept", acc_at_done - a0, 1);
        k = 0;
        while (n_acc < a0 + 2 && k < 10) begin
            @(negedge clk);
            k++;
        end
        chk("held_reaccept_count", n_acc - a0, 2);
        chk("held_reaccept_cycle", acc_cyc - done_cyc, 1);
        @(posedge clk);
        #1 i_req_vld = 1'b0;
        d0 = n_done;
        wait_done(d0, 100);
        chk("held_second_cnt", done_cnt_seen, 4);

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
